complex_divider: RTL and testbench

- Sequential complex divider: computes (Re_in_1 + j·Im_in_1) / (Re_in_2 + j·Im_in_2) as a signed fixed-point result.
- Inverse companion of the team's time-multiplexed complex multiplier, used to undo channel/gain products upstream of it.
- One registered 8x8 signed multiplier is reused for all products, followed by two parallel radix-2 restoring dividers.
- Single-sample, non-pipelined; a busy flag throttles the source.

---
 rtl/complex_divider.sv | 209 ++++++++++++++++++++
 tb/tb_complex_divider.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/complex_divider.sv
// Sequential complex divider (a+jb)/(c+jd): one shared 8x8 multiplier, then two radix-2 restoring dividers.
// Define CPLX_DIV_SATURATE_EN to clamp overflowing components and add the sat_out port.
module complex_divider #(
  parameter int OUT_W = 16,
  parameter int FRAC  = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    data_valid_in,
  input  logic signed [7:0]       Re_in_1,
  input  logic signed [7:0]       Im_in_1,
  input  logic signed [7:0]       Re_in_2,
  input  logic signed [7:0]       Im_in_2,
  output logic signed [OUT_W-1:0] Re_out,
  output logic signed [OUT_W-1:0] Im_out,
  output logic                    data_valid_out,
  output logic                    div_by_zero_out,
  output logic                    busy_out
`ifdef CPLX_DIV_SATURATE_EN
  ,
  output logic                    sat_out
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_NORM = 3'd2;
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  localparam int WW    = 17 + OUT_W;
  localparam int CNT_W = $clog2(OUT_W);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(6);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(OUT_W - 1);

  logic [2:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic signed [7:0]  op_a, op_b, op_c, op_d;
  logic signed [7:0]  mul_x, mul_y;
  logic signed [15:0] prod;
  logic signed [16:0] prod_ext;
  logic signed [16:0] acc_re, acc_im;
  logic [16:0]        acc_d;
  logic               neg_re, neg_im, zero, ovf_re, ovf_im;
  logic [17:0]        rem_re, rem_im;
  logic [OUT_W-1:0]   num_re, num_im, quo_re, quo_im;

  // One restoring step: returns {quotient_bit, new_remainder}.
  function automatic logic [18:0] div_step(input logic [17:0] rem, input logic nb,
                                           input logic [16:0] den);
    logic [17:0] sh;
    sh = {rem[16:0], nb};
    if (sh >= {1'b0, den}) return {1'b1, sh - {1'b0, den}};
    return {1'b0, sh};
  endfunction

  assign busy_out = (state != S_IDLE);
  assign prod_ext = {prod[15], prod};

  // Product schedule: ac, bd, bc, ad, cc, dd.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    mul_x = op_a;
    mul_y = op_c;
    case (cnt)
      CNT_W'(1): begin mul_x = op_b; mul_y = op_d; end
      CNT_W'(2): begin mul_x = op_b; mul_y = op_c; end
      CNT_W'(3): begin mul_x = op_a; mul_y = op_d; end
      CNT_W'(4): begin mul_x = op_c; mul_y = op_c; end
      CNT_W'(5): begin mul_x = op_d; mul_y = op_d; end
      default:   ;
    endcase
  end

  logic [16:0]    mag_re, mag_im, hi_re, hi_im;
  logic [WW-1:0]  x_re, x_im, d_lim;
  logic [17:0]    seed_re, seed_im;

  // Dividend X = |N|<<FRAC. Only the low OUT_W quotient bits are kept, so the
  // divider starts from (X >> OUT_W) mod D and shifts in just the low OUT_W bits.
  always_comb begin
    mag_re  = acc_re[16] ? $unsigned(-acc_re) : $unsigned(acc_re);
    mag_im  = acc_im[16] ? $unsigned(-acc_im) : $unsigned(acc_im);
    x_re    = WW'(mag_re) << FRAC;
    x_im    = WW'(mag_im) << FRAC;
    d_lim   = WW'(acc_d) << (OUT_W - 1);
    hi_re   = 17'(x_re >> OUT_W);
    hi_im   = 17'(x_im >> OUT_W);
    seed_re = '0;
    seed_im = '0;
    if (acc_d != '0) begin
      seed_re = 18'(hi_re % acc_d);
      seed_im = 18'(hi_im % acc_d);
    end
  end

  logic [18:0] step_re, step_im;
  always_comb begin
    step_re = div_step(rem_re, num_re[OUT_W-1], acc_d);
    step_im = div_step(rem_im, num_im[OUT_W-1], acc_d);
  end

  logic [OUT_W-1:0] res_re, res_im;
  always_comb begin
    res_re = neg_re ? -quo_re : quo_re;
    res_im = neg_im ? -quo_im : quo_im;
`ifdef CPLX_DIV_SATURATE_EN
    if (ovf_re) res_re = neg_re ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    if (ovf_im) res_im = neg_im ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
`endif
    if (zero) begin
      res_re = '0;
      res_im = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      {op_a, op_b, op_c, op_d} <= '0;
      prod            <= '0;
      acc_re          <= '0;
      acc_im          <= '0;
      acc_d           <= '0;
      {neg_re, neg_im, zero, ovf_re, ovf_im} <= '0;
      rem_re          <= '0;
      rem_im          <= '0;
      num_re          <= '0;
      num_im          <= '0;
      quo_re          <= '0;
      quo_im          <= '0;
      Re_out          <= '0;
      Im_out          <= '0;
      data_valid_out  <= 1'b0;
      div_by_zero_out <= 1'b0;
`ifdef CPLX_DIV_SATURATE_EN
      sat_out         <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      data_valid_out <= 1'b0;
`ifdef CPLX_DIV_SATURATE_EN
      sat_out        <= 1'b0;
`endif
      case (state)
        S_IDLE: if (data_valid_in) begin
          op_a   <= Re_in_1;
          op_b   <= Im_in_1;
          op_c   <= Re_in_2;
          op_d   <= Im_in_2;
          acc_re <= '0;
          acc_im <= '0;
          acc_d  <= '0;
          cnt    <= '0;
          state  <= S_MUL;
        end
        S_MUL: begin
          prod <= 16'(mul_x) * 16'(mul_y);
          // prod holds the product issued on the previous cycle.
          case (cnt)
            CNT_W'(1), CNT_W'(2): acc_re <= acc_re + prod_ext;
            CNT_W'(3):            acc_im <= acc_im + prod_ext;
            CNT_W'(4):            acc_im <= acc_im - prod_ext;
            CNT_W'(5), CNT_W'(6): acc_d  <= acc_d + $unsigned(prod_ext);
            default:              ;
          endcase
          cnt <= cnt + 1'b1;
          if (cnt == MUL_LAST) state <= S_NORM;
        end
        S_NORM: begin
          neg_re <= acc_re[16];
          neg_im <= acc_im[16];
          zero   <= (acc_d == '0);
          ovf_re <= (x_re >= d_lim);
          ovf_im <= (x_im >= d_lim);
          rem_re <= seed_re;
          rem_im <= seed_im;
          num_re <= x_re[OUT_W-1:0];
          num_im <= x_im[OUT_W-1:0];
          cnt    <= '0;
          state  <= S_DIV;
        end
        S_DIV: begin
          rem_re <= step_re[17:0];
          rem_im <= step_im[17:0];
          quo_re <= {quo_re[OUT_W-2:0], step_re[18]};
          quo_im <= {quo_im[OUT_W-2:0], step_im[18]};
          num_re <= num_re << 1;
          num_im <= num_im << 1;
          cnt    <= cnt + 1'b1;
          if (cnt == DIV_LAST) state <= S_OUT;
        end
        S_OUT: begin
          Re_out          <= res_re;
          Im_out          <= res_im;
          data_valid_out  <= 1'b1;
          div_by_zero_out <= zero;
`ifdef CPLX_DIV_SATURATE_EN
          sat_out         <= ~zero & (ovf_re | ovf_im);
`endif
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_divider.sv
// Self-checking bench for complex_divider: two instances (FRAC=7 and FRAC=9) share one stimulus
// stream and are compared against an arithmetic reference model of the complex quotient.
module tb_complex_divider;

  localparam int OUT_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic valid;
  logic signed [7:0] a_i, b_i, c_i, d_i;
  logic signed [15:0] re0, im0, re1, im1;
  logic dv0, dz0, busy0, dv1, dz1, busy1;
`ifdef CPLX_DIV_SATURATE_EN
  logic sat0, sat1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  complex_divider #(.OUT_W(OUT_W), .FRAC(7)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_valid_in(valid),
    .Re_in_1(a_i), .Im_in_1(b_i), .Re_in_2(c_i), .Im_in_2(d_i),
    .Re_out(re0), .Im_out(im0), .data_valid_out(dv0),
    .div_by_zero_out(dz0), .busy_out(busy0)
`ifdef CPLX_DIV_SATURATE_EN
    , .sat_out(sat0)
`endif
  );

  complex_divider #(.OUT_W(OUT_W), .FRAC(9)) u_ovf (
    .clk(clk), .rst_n(rst_n), .data_valid_in(valid),
    .Re_in_1(a_i), .Im_in_1(b_i), .Re_in_2(c_i), .Im_in_2(d_i),
    .Re_out(re1), .Im_out(im1), .data_valid_out(dv1),
    .div_by_zero_out(dz1), .busy_out(busy1)
`ifdef CPLX_DIV_SATURATE_EN
    , .sat_out(sat1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // One quotient component: truncating division, then wrap or clamp to 16 bits.
  function automatic longint comp(input longint n, input longint den, input int frac,
                                  output bit s);
    longint q;
    logic [63:0] qb;
    s = 1'b0;
`ifdef CPLX_DIV_SATURATE_EN
    begin
      longint mag;
      mag = (n < 0) ? -n : n;
      if ((mag <<< frac) >= (den <<< (OUT_W - 1))) begin
        s = 1'b1;
        return (n < 0) ? -32768 : 32767;
      end
    end
`endif
    q  = (n * (longint'(1) <<< frac)) / den;
    qb = q;
    return longint'($signed(qb[15:0]));
  endfunction

  function automatic void model(input int a, input int b, input int c, input int d,
                                input int frac, output longint re, output longint im,
                                output bit dz, output bit sat);
    longint nre, nim, den;
    bit s1, s2;
    nre = a * c + b * d;
    nim = b * c - a * d;
    den = c * c + d * d;
    dz  = (den == 0);
    sat = 1'b0;
    re  = 0;
    im  = 0;
    if (!dz) begin
      re  = comp(nre, den, frac, s1);
      im  = comp(nim, den, frac, s2);
      sat = s1 | s2;
    end
  endfunction

  task automatic drive_accept(input int a, input int b, input int c, input int d);
    a_i = 8'(a); b_i = 8'(b); c_i = 8'(c); d_i = 8'(d);
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic start(input int a, input int b, input int c, input int d);
    @(negedge clk);
    drive_accept(a, b, c, d);
  endtask

  // Counts edges after the accepting edge (offset = edges already consumed).
  task automatic wait_done(input int offset, output int lat);
    bit seen = 1'b0;
    lat = offset;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (dv0) seen = 1'b1;
    end
    if (!seen) check("dv_timeout", longint'(dv0), 1);
  endtask

  task automatic check_result(input string tag, input int a, input int b, input int c,
                              input int d, input int lat);
    longint re, im;
    bit dz, sat;
    check({tag, "_latency"}, lat, 25);
    model(a, b, c, d, 7, re, im, dz, sat);
    check({tag, "_re"}, re0, re);
    check({tag, "_im"}, im0, im);
    check({tag, "_dz"}, longint'(dz0), longint'(dz));
`ifdef CPLX_DIV_SATURATE_EN
    check({tag, "_sat"}, longint'(sat0), longint'(sat));
`endif
    model(a, b, c, d, 9, re, im, dz, sat);
    check({tag, "_f9_dv"}, longint'(dv1), 1);
    check({tag, "_f9_re"}, re1, re);
    check({tag, "_f9_im"}, im1, im);
    check({tag, "_f9_dz"}, longint'(dz1), longint'(dz));
`ifdef CPLX_DIV_SATURATE_EN
    check({tag, "_f9_sat"}, longint'(sat1), longint'(sat));
`endif
  endtask

  task automatic pulse_and_hold(input string tag, input int a, input int b, input int c,
                                input int d);
    longint re, im;
    bit dz, sat;
    model(a, b, c, d, 7, re, im, dz, sat);
    @(posedge clk);
    #1;
    check({tag, "_pulse_end"}, longint'(dv0), 0);
    check({tag, "_hold_re"}, re0, re);
  endtask

  task automatic run_op(input string tag, input int a, input int b, input int c, input int d);
    int lat;
    start(a, b, c, d);
    check({tag, "_busy"}, longint'(busy0), 1);
    wait_done(0, lat);
    check_result(tag, a, b, c, d, lat);
    pulse_and_hold(tag, a, b, c, d);
  endtask

  initial begin
    int lat;
    int dv_count;
    rst_n = 1'b0;
    valid = 1'b0;
    a_i = '0; b_i = '0; c_i = '0; d_i = '0;
    #12;
    check("rst_re", re0, 0);
    check("rst_im", im0, 0);
    check("rst_dv", longint'(dv0), 0);
    check("rst_dz", longint'(dz0), 0);
    check("rst_busy", longint'(busy0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("basic", 3, 4, 1, 2);
    check("basic_re_lit", re0, 281);
    check("basic_im_lit", im0, -51);
    run_op("imag_div", 100, 0, 0, 1);
    check("imag_div_im_lit", im0, -12800);
    run_op("neg_full", -128, -128, 1, 0);
    check("neg_full_re_lit", re0, -16384);
    run_op("div_zero", 5, -7, 0, 0);
    check("div_zero_dz_lit", longint'(dz0), 1);
    run_op("ovf_pos", 127, 0, 1, 0);
`ifdef CPLX_DIV_SATURATE_EN
    check("ovf_pos_sat_lit", re1, 32767);
`else
    check("ovf_pos_wrap_lit", re1, -512);
`endif
    run_op("ovf_neg", -128, 0, 1, 0);

    // Busy handling: a strobe while busy is ignored, one in the valid cycle is taken.
    start(10, -20, 3, -4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    a_i = 8'sd77; b_i = 8'sd1; c_i = 8'sd2; d_i = -8'sd9;
    valid = 1'b1;
    check("busy_mid", longint'(busy0), 1);
    @(posedge clk);
    #1 valid = 1'b0;
    wait_done(4, lat);
    check_result("busy_first", 10, -20, 3, -4, lat);
    check("busy_in_dv_cycle", longint'(busy0), 0);
    drive_accept(-50, 33, -7, 5);
    wait_done(0, lat);
    check_result("third", -50, 33, -7, 5, lat);
    pulse_and_hold("third", -50, 33, -7, 5);

    // Asynchronous reset while dividing.
    start(60, 60, 2, 1);
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_re", re0, 0);
    check("arst_im", im0, 0);
    check("arst_busy", longint'(busy0), 0);
    #3 rst_n = 1'b1;
    dv_count = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (dv0) dv_count++;
    end
    check("arst_no_dv", dv_count, 0);
    run_op("after_arst", 60, 60, 2, 1);

    for (int i = 0; i < 30; i++) begin
      int a, b, c, d;
      a = int'($urandom_range(0, 255)) - 128;
      b = int'($urandom_range(0, 255)) - 128;
      c = int'($urandom_range(0, 255)) - 128;
      d = int'($urandom_range(0, 255)) - 128;
      if (i % 8 == 0) begin c = 0; d = 0; end
      else if (i % 5 == 0) begin c = int'($urandom_range(0, 2)) - 1; d = 0; end
      run_op($sformatf("rnd%0d", i), a, b, c, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
